// File: rtl/lnrv_icb_splt.sv
// lnrv_icb_splt -- ICB 1-to-N splitter.
//
// Routes each command from one upstream ICB master to one of P_ICB_COUNT
// downstream slaves by base/mask address decode. Responses return to the
// master in command order. Order is kept by allowing outstanding commands
// to only one target at a time. A new target must wait until every
// response from the previous target has been returned.
//
// Optional feature macro: LNRV_ICB_SPLT_ERR_SLV_EN
//   defined     : unmapped addresses go to an internal single-entry error
//                 slave that answers err=1, rdata=0 one cycle later.
//   not defined : unmapped addresses route to slave 0.
//
// Ports
//   clk, reset                : clock, asynchronous active-high reset
//   m_icb_cmd_*               : upstream command (vld/rdy/write/addr/wdata/wstrb/size)
//   m_icb_rsp_*               : upstream response (vld/rdy/err/rdata)
//   sn_icb_cmd_*              : per-slave commands, payload packed slot i at [i*W +: W]
//   sn_icb_rsp_*              : per-slave responses, rdata packed the same way
module lnrv_icb_splt #(
  parameter int P_ADDR_WIDTH = 32,
  parameter int P_DATA_WIDTH = 32,
  parameter int P_ICB_COUNT  = 4,
  parameter int P_OTS_COUNT  = 2,
  parameter logic [P_ICB_COUNT*P_ADDR_WIDTH-1:0] P_SLV_BASE =
    {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [P_ICB_COUNT*P_ADDR_WIDTH-1:0] P_SLV_MASK = {4{32'hF000_0000}}
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    m_icb_cmd_vld,
  output logic                                    m_icb_cmd_rdy,
  input  logic                                    m_icb_cmd_write,
  input  logic [P_ADDR_WIDTH-1:0]                 m_icb_cmd_addr,
  input  logic [P_DATA_WIDTH-1:0]                 m_icb_cmd_wdata,
  input  logic [P_DATA_WIDTH/8-1:0]               m_icb_cmd_wstrb,
  input  logic [2:0]                              m_icb_cmd_size,
  output logic                                    m_icb_rsp_vld,
  input  logic                                    m_icb_rsp_rdy,
  output logic                                    m_icb_rsp_err,
  output logic [P_DATA_WIDTH-1:0]                 m_icb_rsp_rdata,
  output logic [P_ICB_COUNT-1:0]                  sn_icb_cmd_vld,
  input  logic [P_ICB_COUNT-1:0]                  sn_icb_cmd_rdy,
  output logic [P_ICB_COUNT-1:0]                  sn_icb_cmd_write,
  output logic [P_ICB_COUNT*P_ADDR_WIDTH-1:0]     sn_icb_cmd_addr,
  output logic [P_ICB_COUNT*P_DATA_WIDTH-1:0]     sn_icb_cmd_wdata,
  output logic [P_ICB_COUNT*(P_DATA_WIDTH/8)-1:0] sn_icb_cmd_wstrb,
  output logic [P_ICB_COUNT*3-1:0]                sn_icb_cmd_size,
  input  logic [P_ICB_COUNT-1:0]                  sn_icb_rsp_vld,
  output logic [P_ICB_COUNT-1:0]                  sn_icb_rsp_rdy,
  input  logic [P_ICB_COUNT-1:0]                  sn_icb_rsp_err,
  input  logic [P_ICB_COUNT*P_DATA_WIDTH-1:0]     sn_icb_rsp_rdata
);

  localparam int ID_W  = $clog2(P_ICB_COUNT + 1);
  localparam int CNT_W = $clog2(P_OTS_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] OTS_MAX  = CNT_W'(P_OTS_COUNT);
`ifdef LNRV_ICB_SPLT_ERR_SLV_EN
  localparam logic [ID_W-1:0]  ERR_ID   = ID_W'(P_ICB_COUNT);
  localparam logic [ID_W-1:0]  MISS_ID  = ERR_ID;
`else
  localparam logic [ID_W-1:0]  MISS_ID  = {ID_W{1'b0}};
`endif

  logic [CNT_W-1:0]       ots_cnt_r;
  logic [ID_W-1:0]        tgt_id_r;
  logic [ID_W-1:0]        dec_id_s;
  logic                   ots_zero_s;
  logic                   allow_s;
  logic                   tgt_cmd_rdy_s;
  logic                   cmd_hsk_s;
  logic                   rsp_hsk_s;
  logic [P_ICB_COUNT-1:0] rsp_sel_s;
`ifdef LNRV_ICB_SPLT_ERR_SLV_EN
  logic                   err_vld_r;
  logic                   err_sel_s;
  logic                   err_rsp_rdy_s;
  logic                   err_cmd_rdy_s;
  logic                   err_cmd_hsk_s;
`endif

  // Address decode; scanning from the top slot down lets the lowest match win.
  always_comb begin
    dec_id_s = MISS_ID;
    for (int i = P_ICB_COUNT - 1; i >= 0; i--) begin
      if ((m_icb_cmd_addr & P_SLV_MASK[i*P_ADDR_WIDTH +: P_ADDR_WIDTH]) ==
          (P_SLV_BASE[i*P_ADDR_WIDTH +: P_ADDR_WIDTH] & P_SLV_MASK[i*P_ADDR_WIDTH +: P_ADDR_WIDTH])) begin
        dec_id_s = ID_W'(i);
      end else begin
        dec_id_s = dec_id_s;
      end
    end
  end

  assign ots_zero_s = (ots_cnt_r == CNT_ZERO);
  // Credits only come back at the clock edge, so a same-cycle response
  // handshake never lets an extra command through.
  assign allow_s    = ots_zero_s || ((tgt_id_r == dec_id_s) && (ots_cnt_r < OTS_MAX));

`ifdef LNRV_ICB_SPLT_ERR_SLV_EN
  assign err_sel_s     = !ots_zero_s && (tgt_id_r == ERR_ID);
  // With no window open any leftover error response is simply dropped.
  assign err_rsp_rdy_s = ots_zero_s | (err_sel_s & m_icb_rsp_rdy);
  assign err_cmd_rdy_s = ~err_vld_r | err_rsp_rdy_s;
  assign err_cmd_hsk_s = cmd_hsk_s & (dec_id_s == ERR_ID);
`endif

  // Ready of the decoded target, built as an AND-OR select.
  always_comb begin
    tgt_cmd_rdy_s = 1'b0;
    for (int i = 0; i < P_ICB_COUNT; i++) begin
      tgt_cmd_rdy_s = tgt_cmd_rdy_s | ((dec_id_s == ID_W'(i)) & sn_icb_cmd_rdy[i]);
    end
`ifdef LNRV_ICB_SPLT_ERR_SLV_EN
    tgt_cmd_rdy_s = tgt_cmd_rdy_s | ((dec_id_s == ERR_ID) & err_cmd_rdy_s);
`endif
  end

  assign m_icb_cmd_rdy = allow_s & tgt_cmd_rdy_s;
  assign cmd_hsk_s     = m_icb_cmd_vld & m_icb_cmd_rdy;

  // Command valid goes only to the decoded slave, and only while allowed.
  always_comb begin
    sn_icb_cmd_vld = {P_ICB_COUNT{1'b0}};
    for (int i = 0; i < P_ICB_COUNT; i++) begin
      sn_icb_cmd_vld[i] = m_icb_cmd_vld & allow_s & (dec_id_s == ID_W'(i));
    end
  end

  // Payload is broadcast; only the valid bit selects the slave.
  assign sn_icb_cmd_write = {P_ICB_COUNT{m_icb_cmd_write}};
  assign sn_icb_cmd_addr  = {P_ICB_COUNT{m_icb_cmd_addr}};
  assign sn_icb_cmd_wdata = {P_ICB_COUNT{m_icb_cmd_wdata}};
  assign sn_icb_cmd_wstrb = {P_ICB_COUNT{m_icb_cmd_wstrb}};
  assign sn_icb_cmd_size  = {P_ICB_COUNT{m_icb_cmd_size}};

  // Which slave port owns the response path (none when no window is open).
  always_comb begin
    rsp_sel_s = {P_ICB_COUNT{1'b0}};
    for (int i = 0; i < P_ICB_COUNT; i++) begin
      rsp_sel_s[i] = !ots_zero_s && (tgt_id_r == ID_W'(i));
    end
  end

  // Response mux; an idle splitter holds every rsp_rdy high to drain stale responses.
  always_comb begin
    m_icb_rsp_vld   = 1'b0;
    m_icb_rsp_err   = 1'b0;
    m_icb_rsp_rdata = {P_DATA_WIDTH{1'b0}};
    sn_icb_rsp_rdy  = {P_ICB_COUNT{1'b0}};
    for (int i = 0; i < P_ICB_COUNT; i++) begin
      m_icb_rsp_vld     = m_icb_rsp_vld | (rsp_sel_s[i] & sn_icb_rsp_vld[i]);
      m_icb_rsp_err     = m_icb_rsp_err | (rsp_sel_s[i] & sn_icb_rsp_err[i]);
      m_icb_rsp_rdata   = m_icb_rsp_rdata |
                          ({P_DATA_WIDTH{rsp_sel_s[i]}} & sn_icb_rsp_rdata[i*P_DATA_WIDTH +: P_DATA_WIDTH]);
      sn_icb_rsp_rdy[i] = ots_zero_s | (rsp_sel_s[i] & m_icb_rsp_rdy);
    end
`ifdef LNRV_ICB_SPLT_ERR_SLV_EN
    m_icb_rsp_vld = m_icb_rsp_vld | (err_sel_s & err_vld_r);
    m_icb_rsp_err = m_icb_rsp_err | (err_sel_s & err_vld_r);
`endif
  end

  assign rsp_hsk_s = m_icb_rsp_vld & m_icb_rsp_rdy;

  // Outstanding counter and window target.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ots_cnt_r <= CNT_ZERO;
      tgt_id_r  <= {ID_W{1'b0}};
    end else begin
      case ({cmd_hsk_s, rsp_hsk_s})
        2'b10:   ots_cnt_r <= ots_cnt_r + CNT_ONE;
        2'b01:   ots_cnt_r <= ots_cnt_r - CNT_ONE;
        default: ots_cnt_r <= ots_cnt_r;
      endcase
      if (cmd_hsk_s) begin
        tgt_id_r <= dec_id_s;
      end else begin
        tgt_id_r <= tgt_id_r;
      end
    end
  end

`ifdef LNRV_ICB_SPLT_ERR_SLV_EN
  // Single-entry error slave: respond the cycle after accepting, hold until taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_vld_r <= 1'b0;
    end else if (err_cmd_hsk_s) begin
      err_vld_r <= 1'b1;
    end else if (err_vld_r && err_rsp_rdy_s) begin
      err_vld_r <= 1'b0;
    end else begin
      err_vld_r <= err_vld_r;
    end
  end
`endif

endmodule

// File: tb/tb_lnrv_icb_splt.sv
// Scoreboard bench for lnrv_icb_splt with the default 4-slave map.
// Slave i answers a read with addr ^ K[i] after dly[i] cycles, and a write with 0.
module tb_lnrv_icb_splt;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int N  = 4;
  localparam int SW = DW / 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            m_icb_cmd_vld, m_icb_cmd_rdy, m_icb_cmd_write;
  logic [AW-1:0]   m_icb_cmd_addr;
  logic [DW-1:0]   m_icb_cmd_wdata;
  logic [SW-1:0]   m_icb_cmd_wstrb;
  logic [2:0]      m_icb_cmd_size;
  logic            m_icb_rsp_vld, m_icb_rsp_rdy, m_icb_rsp_err;
  logic [DW-1:0]   m_icb_rsp_rdata;
  logic [N-1:0]    sn_icb_cmd_vld, sn_icb_cmd_rdy, sn_icb_cmd_write;
  logic [N*AW-1:0] sn_icb_cmd_addr;
  logic [N*DW-1:0] sn_icb_cmd_wdata;
  logic [N*SW-1:0] sn_icb_cmd_wstrb;
  logic [N*3-1:0]  sn_icb_cmd_size;
  logic [N-1:0]    sn_icb_rsp_vld, sn_icb_rsp_rdy, sn_icb_rsp_err;
  logic [N*DW-1:0] sn_icb_rsp_rdata;

  always #5 clk = ~clk;

  lnrv_icb_splt #(.P_ADDR_WIDTH(AW), .P_DATA_WIDTH(DW), .P_ICB_COUNT(N), .P_OTS_COUNT(2)) dut (
    .clk(clk), .reset(reset),
    .m_icb_cmd_vld(m_icb_cmd_vld), .m_icb_cmd_rdy(m_icb_cmd_rdy), .m_icb_cmd_write(m_icb_cmd_write),
    .m_icb_cmd_addr(m_icb_cmd_addr), .m_icb_cmd_wdata(m_icb_cmd_wdata),
    .m_icb_cmd_wstrb(m_icb_cmd_wstrb), .m_icb_cmd_size(m_icb_cmd_size),
    .m_icb_rsp_vld(m_icb_rsp_vld), .m_icb_rsp_rdy(m_icb_rsp_rdy),
    .m_icb_rsp_err(m_icb_rsp_err), .m_icb_rsp_rdata(m_icb_rsp_rdata),
    .sn_icb_cmd_vld(sn_icb_cmd_vld), .sn_icb_cmd_rdy(sn_icb_cmd_rdy), .sn_icb_cmd_write(sn_icb_cmd_write),
    .sn_icb_cmd_addr(sn_icb_cmd_addr), .sn_icb_cmd_wdata(sn_icb_cmd_wdata),
    .sn_icb_cmd_wstrb(sn_icb_cmd_wstrb), .sn_icb_cmd_size(sn_icb_cmd_size),
    .sn_icb_rsp_vld(sn_icb_rsp_vld), .sn_icb_rsp_rdy(sn_icb_rsp_rdy),
    .sn_icb_rsp_err(sn_icb_rsp_err), .sn_icb_rsp_rdata(sn_icb_rsp_rdata)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard of expected upstream responses.
  typedef struct packed { logic [31:0] data; logic err; } exp_t;
  exp_t sb_q[$];

  // Response monitor: compares at the negedge before each response handshake.
  always @(negedge clk) begin
    if (m_icb_rsp_vld && m_icb_rsp_rdy) begin
      if (sb_q.size() == 0) begin
        check("rsp_unexpected", {32'h0, m_icb_rsp_rdata}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("rsp_rdata", {32'h0, m_icb_rsp_rdata}, {32'h0, e.data});
        check("rsp_err", {63'h0, m_icb_rsp_err}, {63'h0, e.err});
      end
    end
  end

  // Behavioural slaves.
  logic [31:0] K [N] = '{32'h1111_0000, 32'hCEAD_BEEB, 32'h2222_0000, 32'h3333_0000};
  int          dly [N] = '{1, 1, 1, 1};
  logic [31:0] pd  [N][16];
  int          pdue[N][16];
  int          wp  [N] = '{0, 0, 0, 0};
  int          rp  [N] = '{0, 0, 0, 0};
  int          cyc = 0;
  bit          cmd_h [N];
  bit          rsp_h [N];
  logic [31:0] cap   [N];

  initial begin
    sn_icb_cmd_rdy   = {N{1'b1}};
    sn_icb_rsp_vld   = {N{1'b0}};
    sn_icb_rsp_err   = {N{1'b0}};
    sn_icb_rsp_rdata = {N*DW{1'b0}};
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        cmd_h[i] = sn_icb_cmd_vld[i] & sn_icb_cmd_rdy[i];
        rsp_h[i] = sn_icb_rsp_vld[i] & sn_icb_rsp_rdy[i];
        cap[i]   = sn_icb_cmd_write[i] ? 32'h0 : (sn_icb_cmd_addr[i*AW +: AW] ^ K[i]);
      end
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < N; i++) begin
        if (rsp_h[i]) rp[i]++;
        if (cmd_h[i]) begin
          pd[i][wp[i] % 16]   = cap[i];
          pdue[i][wp[i] % 16] = cyc + dly[i] - 1;
          wp[i]++;
        end
        if (rp[i] != wp[i] && pdue[i][rp[i] % 16] <= cyc) begin
          sn_icb_rsp_vld[i]            = 1'b1;
          sn_icb_rsp_rdata[i*DW +: DW] = pd[i][rp[i] % 16];
        end else begin
          sn_icb_rsp_vld[i]            = 1'b0;
          sn_icb_rsp_rdata[i*DW +: DW] = 32'h0;
        end
      end
    end
  end

  // Issue one command (called just after a posedge); returns the stall cycle count.
  task automatic issue(input logic [31:0] addr, input logic wr, input logic [31:0] exp_data,
                       input logic exp_err, input logic [N-1:0] exp_vld, output int stalls);
    exp_t e;
    bit   bad_stall = 1'b0;
    bit   bad_bcast = 1'b0;
    bit   timeout   = 1'b0;
    m_icb_cmd_vld   = 1'b1;
    m_icb_cmd_addr  = addr;
    m_icb_cmd_write = wr;
    m_icb_cmd_wdata = addr ^ 32'h5A5A_5A5A;
    m_icb_cmd_wstrb = 4'hF;
    m_icb_cmd_size  = 3'd2;
    e.data = exp_data;
    e.err  = exp_err;
    sb_q.push_back(e);
    stalls = 0;
    forever begin
      @(negedge clk);
      if (m_icb_cmd_rdy) break;
      if (sn_icb_cmd_vld != {N{1'b0}}) bad_stall = 1'b1;
      stalls++;
      if (stalls >= 60) begin
        timeout = 1'b1;
        break;
      end
    end
    if (timeout) begin
      check("cmd_timeout", 64'd60, 64'd0);
      void'(sb_q.pop_back());
    end else begin
      check("cmd_vld_onehot", {60'h0, sn_icb_cmd_vld}, {60'h0, exp_vld});
      for (int i = 0; i < N; i++)
        if (sn_icb_cmd_addr[i*AW +: AW] !== addr) bad_bcast = 1'b1;
      check("cmd_addr_bcast", {63'h0, bad_bcast}, 64'h0);
    end
    if (stalls > 0) check("stall_cmd_vld_zero", {63'h0, bad_stall}, 64'h0);
    @(posedge clk);
    #1;
    m_icb_cmd_vld = 1'b0;
  endtask

  // Wait for the scoreboard to empty, bounded.
  task automatic wait_idle(input string name);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0) break;
    end
    check(name, 64'(sb_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, want finish before 200us");
    $fatal(1);
  end

  initial begin
    int st;
    bit bad;
    reset           = 1'b1;
    m_icb_cmd_vld   = 1'b0;
    m_icb_cmd_write = 1'b0;
    m_icb_cmd_addr  = 32'h0;
    m_icb_cmd_wdata = 32'h0;
    m_icb_cmd_wstrb = 4'h0;
    m_icb_cmd_size  = 3'd0;
    m_icb_rsp_rdy   = 1'b1;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_rsp_vld", {63'h0, m_icb_rsp_vld}, 64'h0);
    check("rst_sn_rsp_rdy", {60'h0, sn_icb_rsp_rdy}, 64'hF);
    check("rst_cmd_vld_idle", {60'h0, sn_icb_cmd_vld}, 64'h0);
    check("rst_cmd_rdy", {63'h0, m_icb_cmd_rdy}, 64'h1);
    // Combinational path during reset, withdrawn before the next edge.
    m_icb_cmd_addr = 32'h2000_0000;
    m_icb_cmd_vld  = 1'b1;
    #1;
    check("rst_cmd_vld_comb", {60'h0, sn_icb_cmd_vld}, 64'h4);
    #1;
    m_icb_cmd_vld = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Single read to slave 1.
    issue(32'h1000_0004, 1'b0, 32'hDEAD_BEEF, 1'b0, 4'b0010, st);
    check("s1_stall", 64'(st), 64'd0);
    wait_idle("s1_drain");

    // Region boundary, then a target switch that must wait one cycle.
    issue(32'h1FFF_FFFC, 1'b0, 32'hD152_4117, 1'b0, 4'b0010, st);
    issue(32'h2000_0000, 1'b0, 32'h0222_0000, 1'b0, 4'b0100, st);
    check("boundary_switch_stall", 64'(st), 64'd1);
    wait_idle("boundary_drain");

    // Outstanding limit with slow slave 0; third command stalls until first response.
    dly[0] = 3;
    issue(32'h0000_0000, 1'b0, 32'h1111_0000, 1'b0, 4'b0001, st);
    check("ots_a_stall", 64'(st), 64'd0);
    issue(32'h0000_0004, 1'b0, 32'h1111_0004, 1'b0, 4'b0001, st);
    check("ots_b_stall", 64'(st), 64'd0);
    issue(32'h0000_0008, 1'b0, 32'h1111_0008, 1'b0, 4'b0001, st);
    check("ots_c_stall", 64'(st), 64'd2);
    // Third command issued in the same cycle as the second response.
    @(negedge clk);
    check("ots_simul_hsk", 64'(dut.ots_cnt_r), 64'd1);
    @(posedge clk);
    #1;
    wait_idle("ots_drain");

    // Target switch: slave 2 waits for slave 0's response.
    dly[0] = 4;
    issue(32'h0000_0010, 1'b0, 32'h1111_0010, 1'b0, 4'b0001, st);
    issue(32'h2000_0010, 1'b0, 32'h0222_0010, 1'b0, 4'b0100, st);
    check("switch_stall", 64'(st), 64'd4);
    wait_idle("switch_drain");

    // Unmapped address.
`ifdef LNRV_ICB_SPLT_ERR_SLV_EN
    m_icb_rsp_rdy = 1'b0;
    issue(32'h5000_0000, 1'b1, 32'h0, 1'b1, 4'b0000, st);
    check("err_stall", 64'(st), 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("err_hold", {m_icb_rsp_rdata, 30'h0, m_icb_rsp_err, m_icb_rsp_vld}, 64'h3);
    end
    @(posedge clk);
    #1;
    m_icb_rsp_rdy = 1'b1;
    wait_idle("err_drain");
`else
    issue(32'h5000_0000, 1'b1, 32'h0, 1'b0, 4'b0001, st);
    check("unmapped_stall", 64'(st), 64'd0);
    wait_idle("unmapped_drain");
`endif

    // Reset with two outstanding; late responses must be drained, not forwarded.
    dly[0] = 5;
    issue(32'h0000_0020, 1'b0, 32'h1111_0020, 1'b0, 4'b0001, st);
    issue(32'h0000_0024, 1'b0, 32'h1111_0024, 1'b0, 4'b0001, st);
    check("rstmid_b_stall", 64'(st), 64'd0);
    reset = 1'b1;
    sb_q.delete();
    @(negedge clk);
    check("rstmid_sn_rsp_rdy", {60'h0, sn_icb_rsp_rdy}, 64'hF);
    @(posedge clk);
    #1;
    reset = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (m_icb_rsp_vld !== 1'b0 || sn_icb_rsp_rdy[0] !== 1'b1) bad = 1'b1;
    end
    check("rstmid_no_fwd", {63'h0, bad}, 64'h0);
    check("rstmid_drained", 64'(wp[0] - rp[0]), 64'd0);
    @(posedge clk);
    #1;

    // Normal traffic after reset, slave 3.
    dly[3] = 2;
    issue(32'h3000_0020, 1'b0, 32'h0333_0020, 1'b0, 4'b1000, st);
    check("post_rst_stall", 64'(st), 64'd0);
    wait_idle("post_rst_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/lnrv_icb_splt.md
# lnrv_icb_splt

ICB 1-to-N splitter: routes commands from one upstream ICB master to one of `P_ICB_COUNT` downstream slaves by address decode, and returns each response to the master in command order. It is the fan-out counterpart of the N-to-1 ICB mux and sits between a core or bus mux and the peripheral or memory slaves. In-order return is guaranteed by locking the outstanding window to one target at a time. An optional internal error slave answers unmapped addresses.

## Interface

**Parameters**
- `P_ADDR_WIDTH`, default 32: address width.
- `P_DATA_WIDTH`, default 32: data width. Must be a multiple of 8.
- `P_ICB_COUNT`, default 4: number of slave ports, ≥2.
- `P_OTS_COUNT`, default 2: maximum outstanding commands, ≥1.
- `P_SLV_BASE`, default {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}: packed base addresses. Slot i is bits `[i*P_ADDR_WIDTH +: P_ADDR_WIDTH]`.
- `P_SLV_MASK`, default {4{32'hF000_0000}}: packed region masks, same packing as `P_SLV_BASE`.

**Ports**
- `clk`  in  1  clock.
- `reset`  in  1  one clock; reset is asynchronous and active-high.
- `m_icb_cmd_vld / rdy / write`  in / out / in  1 each  upstream command handshake and write flag.
- `m_icb_cmd_addr / wdata / wstrb / size`  in  `P_ADDR_WIDTH` / `P_DATA_WIDTH` / `P_DATA_WIDTH/8` / 3  upstream command payload.
- `m_icb_rsp_vld / rdy / err`  out / in / out  1 each  upstream response handshake and error flag.
- `m_icb_rsp_rdata`  out  `P_DATA_WIDTH`  upstream response data.
- `sn_icb_cmd_vld / rdy / write`  out / in / out  `P_ICB_COUNT` each  per-slave command handshake and write flag.
- `sn_icb_cmd_addr / wdata / wstrb / size`  out  N×`P_ADDR_WIDTH` / N×`P_DATA_WIDTH` / N×`P_DATA_WIDTH/8` / N×3  per-slave command payload, packed like the parameters.
- `sn_icb_rsp_vld / rdy / err`  in / out / in  `P_ICB_COUNT` each  per-slave response handshake and error flag.
- `sn_icb_rsp_rdata`  in  N×`P_DATA_WIDTH`  per-slave response data.

## Operation

**Address decode**
- Slave i matches when `(addr & MASK[i]) == (BASE[i] & MASK[i])`.
- If several slaves match, the lowest index wins.
- If no slave matches, the target is the error slave (id N), or slave 0 when the error slave is compiled out (see Configuration).

**State**
- `ots_cnt`: outstanding-command counter, width `clog2(P_OTS_COUNT+1)`.
- `tgt_id`: target of the outstanding window, width `clog2(P_ICB_COUNT+1)`.

**Issue rule**
- `allow = (ots_cnt==0) || (tgt_id==dec_id && ots_cnt<P_OTS_COUNT)`.
- A response handshake in the same cycle does not free a credit for a command in that cycle.

**Command path (combinational)**
- `sn_icb_cmd_vld[dec_id] = m_icb_cmd_vld & allow`. All other bits of `sn_icb_cmd_vld` are 0.
- `m_icb_cmd_rdy = allow & rdy(dec_id)`. The error slave's rdy is 1 when it is idle or its response is being consumed this cycle.
- Payload is broadcast ungated to every slave port.

**Counter and target update**
- On a command handshake: `ots_cnt+1` and `tgt_id <= dec_id`.
- On a response handshake: `ots_cnt-1`.
- Both in the same cycle: `ots_cnt` is unchanged.

**Response path**
- When `ots_cnt != 0`: `m_icb_rsp_* = sn_icb_rsp_*[tgt_id]` and `sn_icb_rsp_rdy[tgt_id] = m_icb_rsp_rdy`. All other rsp_rdy bits are 0.
- When `ots_cnt == 0`: `m_icb_rsp_vld = 0` and all `sn_icb_rsp_rdy = 1`, so stale responses are drained and dropped.

**Error slave**
- Single-entry. It accepts a command and asserts `rsp_vld` with `err=1`, `rdata=0` from the next cycle.
- It holds until `m_icb_rsp_rdy`.

## Timing

- Reset values: `ots_cnt=0`, `tgt_id=0`, error-slave `rsp_vld=0`.
- Hence `m_icb_rsp_vld=0` during reset; all `sn_icb_rsp_rdy=1`.
- `sn_icb_cmd_vld` and `m_icb_cmd_rdy` follow the combinational equations with `ots_cnt=0`.
- Command latency: 0 cycles, pass-through. Response latency to a mapped slave: 0 cycles added.
- Error slave latency: response 1 cycle after the command handshake.
- Throughput to one target: 1 command per cycle while `ots_cnt<P_OTS_COUNT`.
- Target switch: the new target is blocked until `ots_cnt` returns to 0. The first command to it can issue in the cycle after the last response handshake.
- Upstream vld/payload must stay stable until rdy. The block never asserts `sn_icb_cmd_vld` while `allow=0`.
- Reset asserted mid-transaction clears all state immediately. Late slave responses are then drained per the `ots_cnt==0` rule.

## Configuration

- `LNRV_ICB_SPLT_ERR_SLV_EN` defined: unmapped addresses go to the internal error slave and return `err=1`, `rdata=0`. No slave port sees the command.
- Not defined: the error slave logic is absent, and unmapped addresses route to slave 0.

## Test plan

- Read 0x1000_0004; slave 1 answers 0xDEAD_BEEF one cycle later → only `sn_icb_cmd_vld[1]` pulses; `m_icb_rsp_rdata=0xDEAD_BEEF`, `err=0`.
- Back-to-back reads to 0x0000_0000, 0x0000_0004, 0x0000_0008 with `P_OTS_COUNT=2` and slave 0 rsp delayed 3 cycles → the third command stalls (`m_icb_cmd_rdy=0`) until the first response handshake; data returns in order.
- Read to slave 2 while one read to slave 0 is outstanding → `m_icb_cmd_rdy=0` and `sn_icb_cmd_vld[2]=0` until slave 0's response completes; the command issues the next cycle.
- With `LNRV_ICB_SPLT_ERR_SLV_EN`, write 0x5000_0000 → no `sn_icb_cmd_vld`; `m_icb_rsp_vld=1` with `err=1`, `rdata=0` one cycle later; holds for 4 cycles with `m_icb_rsp_rdy=0`.
- Simultaneous command and response handshake at `ots_cnt=1` → `ots_cnt` stays 1.
- Assert `reset` with 2 outstanding; slave asserts rsp_vld after release → `m_icb_rsp_vld` stays 0; the slave's rsp_rdy=1 drains it.
